// File: rtl/ifu_pkg.sv
// Shared encodings for the fetch/PC stage and the controller: PC source select,
// fetch states, instruction field positions and opcode constants.
package ifu_pkg;

    localparam int unsigned PCSRC_W    = 2;
    localparam int unsigned OPCODE_W   = 4;
    localparam int unsigned FUNC_W     = 4;
    localparam int unsigned OPCODE_MSB = 15;
    localparam int unsigned OPCODE_LSB = 12;
    localparam int unsigned FUNC_MSB   = 3;
    localparam int unsigned FUNC_LSB   = 0;
    localparam int unsigned JMP_IMM_W  = 12;

    typedef enum logic [PCSRC_W-1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_JMP    = 2'b01,
        PCSRC_ALUOUT = 2'b10,
        PCSRC_HOLD   = 2'b11
    } pcsrc_e;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_REQ  = 1'b1
    } fetch_state_e;

    localparam logic [OPCODE_W-1:0] OP_JMP = 4'b0011;

endpackage

// File: rtl/ifu_pc_next.sv
// Next-PC selection and PC load-enable; the result equals pc when no load happens.
module ifu_pc_next
    import ifu_pkg::*;
#(
    parameter int unsigned PC_W = 16
) (
    input  logic [PC_W-1:0]      pc,
    input  logic [JMP_IMM_W-1:0] jmp_imm,
    input  logic [PCSRC_W-1:0]   pc_src,
    input  logic                 pc_write,
    input  logic                 pc_beq_cond,
    input  logic                 pc_bnq_cond,
    input  logic                 alu_zero,
    input  logic [PC_W-1:0]      alu_result,
    input  logic [PC_W-1:0]      alu_out_reg,
    output logic [PC_W-1:0]      pc_next_c
);

    logic pc_load_c;

    always_comb begin
        pc_load_c = pc_write | (pc_beq_cond & alu_zero) | (pc_bnq_cond & ~alu_zero);
        pc_next_c = pc;
        if (pc_load_c) begin
            case (pcsrc_e'(pc_src))
                PCSRC_ALU:    pc_next_c = alu_result;
                PCSRC_JMP:    pc_next_c = {pc[PC_W-1:JMP_IMM_W], jmp_imm};
                PCSRC_ALUOUT: pc_next_c = alu_out_reg;
                default:      pc_next_c = pc;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/PC stage: owns PC and IR, fetches over a req/ack memory handshake.
// IFU_FETCH_TIMEOUT_EN adds a fetch watchdog with a sticky fetch_err flag.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned     PC_W     = 16,
    parameter int unsigned     IR_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
`ifdef IFU_FETCH_TIMEOUT_EN
    ,
    parameter int unsigned     TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_start,
    input  logic [PCSRC_W-1:0]  PCSrc,
    input  logic                PCWrite,
    input  logic                PCBEqCond,
    input  logic                PCBNqCond,
    input  logic [PC_W-1:0]     alu_result,
    input  logic [PC_W-1:0]     alu_out_reg,
    input  logic                alu_zero,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [IR_W-1:0]     imem_rdata,
    output logic [PC_W-1:0]     pc,
    output logic [IR_W-1:0]     ir,
    output logic [OPCODE_W-1:0] opcode,
    output logic [FUNC_W-1:0]   func_field,
    output logic                ir_valid,
    output logic                fetch_busy,
    output logic                fetch_err
);

    fetch_state_e    state_q, state_d;
    logic            req_q, req_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            valid_q, valid_d;
    logic [PC_W-1:0] pc_q, pc_next_c;

`ifdef IFU_FETCH_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    ifu_pc_next #(
        .PC_W (PC_W)
    ) u_pc_next (
        .pc          (pc_q),
        .jmp_imm     (ir_q[JMP_IMM_W-1:0]),
        .pc_src      (PCSrc),
        .pc_write    (PCWrite),
        .pc_beq_cond (PCBEqCond),
        .pc_bnq_cond (PCBNqCond),
        .alu_zero    (alu_zero),
        .alu_result  (alu_result),
        .alu_out_reg (alu_out_reg),
        .pc_next_c   (pc_next_c)
    );

    // Fetch FSM next-state and next-register values
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        valid_d = 1'b0;
`ifdef IFU_FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            F_IDLE: begin
                if (fetch_start) begin
                    state_d = F_REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
`ifdef IFU_FETCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            F_REQ: begin
                if (imem_ack) begin
                    state_d = F_IDLE;
                    req_d   = 1'b0;
                    ir_d    = imem_rdata;
                    valid_d = 1'b1;
                end
`ifdef IFU_FETCH_TIMEOUT_EN
                else if (cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = F_IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
`endif
            end
            default: begin
                state_d = F_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= F_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            ir_q    <= '0;
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
`ifdef IFU_FETCH_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            pc_q    <= pc_next_c;
`ifdef IFU_FETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // A fetch is outstanding exactly while the request is raised
    assign imem_req   = req_q;
    assign fetch_busy = req_q;
    assign imem_addr  = addr_q;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign ir_valid   = valid_q;
    assign opcode     = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign func_field = ir_q[FUNC_MSB:FUNC_LSB];

`ifdef IFU_FETCH_TIMEOUT_EN
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch/PC stage that sits directly beside controllerFSM in the 16-bit multicycle core. It owns the PC and the instruction register (IR).
- Consumes the FSM's PC-update and fetch controls; produces the opcode and func_field that the FSM decodes.
- Talks to instruction memory through a req/ack handshake, so it tolerates variable-latency memory.

Parameters:
- PC_W, 16, PC and instruction-address width
- IR_W, 16, instruction width
- RESET_PC, 16'h0000, PC value after reset
- TIMEOUT_CYCLES, 64, watchdog limit; used only with IFU_FETCH_TIMEOUT_EN

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- fetch_start  in  1  pulse from controller: start fetch at current PC
- PCSrc  in  2  next-PC source select
- PCWrite  in  1  unconditional PC load
- PCBEqCond  in  1  load PC if alu_zero
- PCBNqCond  in  1  load PC if !alu_zero
- alu_result  in  PC_W  combinational ALU output
- alu_out_reg  in  PC_W  registered ALU output
- alu_zero  in  1  ALU zero flag
- imem_req  out  1  memory read request
- imem_addr  out  PC_W  read address
- imem_ack  in  1  read data valid
- imem_rdata  in  IR_W  instruction word
- pc  out  PC_W  current PC
- ir  out  IR_W  instruction register
- opcode  out  4  ir[15:12]
- func_field  out  4  ir[3:0]
- ir_valid  out  1  one-cycle pulse: IR updated
- fetch_busy  out  1  fetch outstanding
- fetch_err  out  1  sticky timeout flag; tied 0 without the macro

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC; ir=0; imem_req=0; imem_addr=0; ir_valid=0; fetch_busy=0; fetch_err=0.
  - FSM returns to F_IDLE.
  - A reset during a fetch aborts it; a late ack is ignored.
- FSM states F_IDLE, F_REQ:
  - F_IDLE with fetch_start=1: latch imem_addr<=pc, go to F_REQ, drive imem_req=1 and fetch_busy=1 from the next cycle.
  - F_REQ with imem_ack=0: hold req and addr stable.
  - F_REQ with imem_ack=1: ir<=imem_rdata, ir_valid=1 for exactly the next cycle, req=0, go to F_IDLE.
  - Fetch latency: ack in cycle N gives ir_valid in N+1; minimum start-to-valid is 2 cycles with zero-wait memory.
  - fetch_start while in F_REQ: ignored, no queueing.
  - imem_ack in F_IDLE: ignored; IR is unchanged.
- PC update (independent of FSM, every cycle):
  - Load enable = PCWrite | (PCBEqCond & alu_zero) | (PCBNqCond & ~alu_zero).
  - PCSrc 00: alu_result. 01: jump target {pc[15:12], ir[11:0]}. 10: alu_out_reg. 11: hold pc (no change even if enabled).
  - All values are unsigned PC_W; no overflow detection. 16'hFFFF+1 from the ALU wraps to 0.
- Simultaneous events:
  - PC load in the same cycle as fetch_start: the fetch uses the pre-update pc; the new PC is visible next cycle.
  - PC load during F_REQ: allowed; imem_addr stays latched.
- opcode and func_field are pure slices of the ir register, with no extra delay.

Optional Feature:
- Macro IFU_FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to F_REQ and increments each F_REQ cycle.
  - When it reaches TIMEOUT_CYCLES without ack: abort to F_IDLE, req=0, ir unchanged, no ir_valid, set fetch_err.
  - fetch_err clears only on reset.
  - An ack arriving on the timeout cycle wins: it is accepted normally, with no error.
- Undefined: no counter; F_REQ waits indefinitely; fetch_err is constant 0.

Decomposition:
- Shared package ifu_pkg holds:
  - PCSrc encodings: PCSRC_ALU, PCSRC_JMP, PCSRC_ALUOUT, PCSRC_HOLD
  - opcode/func_field bit positions
  - fetch state encodings F_IDLE, F_REQ
  - Opcode constants shared with controllerFSM, e.g. OP_JMP=4'b0011
- One natural sub-module, ifu_pc_next: combinational next-PC mux plus load-enable logic. The top keeps the FSM, IR, PC register and watchdog.

Test Plan:
- Reset then fetch_start, memory acks 3 cycles later with 16'h8123 → imem_addr=0, req held 3 cycles, ir=16'h8123, opcode=4'h8, func_field=4'h3, one ir_valid pulse.
- PCWrite=1, PCSrc=00, alu_result=16'h0001 in the same cycle as fetch_start → imem_addr=0, pc=1 next cycle.
- Jump: pc=16'h5010, ir=16'h3ABC, PCWrite=1, PCSrc=01 → pc=16'h5ABC. Same with PCSrc=11 → pc stays 16'h5010.
- Branches with PCSrc=10, alu_out_reg=16'h0040:
  - PCBEqCond=1, alu_zero=1 → pc=16'h0040.
  - PCBEqCond=1, alu_zero=0 → pc unchanged.
  - PCBNqCond=1, alu_zero=0 → pc=16'h0040.
- rst_n low mid-F_REQ, then ack arrives after release → req=0 immediately, pc=RESET_PC, ir=0, no ir_valid.
- With IFU_FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4: no ack → req drops after 4 cycles, fetch_err=1 and stays 1 across later successful fetches.
